// File: rtl/mesh_pkg.sv
// Shared packet definitions for the mesh fabric: packet width, header field
// positions and the VC (virtual channel) accessor used by injection logic.
package mesh_pkg;

    localparam int PKT_W = 64;

    // Header layout, MSB first. The VC bit selects the even/odd phase.
    localparam int VC_BIT      = 63;
    localparam int DST_X_LSB   = 56;
    localparam int DST_X_W     = 4;
    localparam int DST_Y_LSB   = 52;
    localparam int DST_Y_W     = 4;
    localparam int SRC_ID_LSB  = 48;
    localparam int SRC_ID_W    = 4;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 48;

    typedef logic [PKT_W-1:0] packet_t;

    // Virtual-channel bit of a packet header.
    function automatic logic pkt_vc(input packet_t pkt);
        return pkt[VC_BIT];
    endfunction

endpackage

// File: rtl/mesh_pkt_fifo.sv
// Small synchronous FIFO for mesh packets. DEPTH must be a power of two
// (pointers wrap naturally); occupancy is kept in its own counter so that
// full and empty are unambiguous. The head reads as zero when empty.
module mesh_pkt_fifo
    import mesh_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type pkt_t = packet_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  pkt_t                       wdata,
    input  logic                       pop,
    output pkt_t                       rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    pkt_t             mem_q [DEPTH];

    // Next pointers and occupancy from this cycle's push/pop.
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first so no latch is inferred; clocked blocks use non-blocking '<='.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage, written at the tail.
    // NOTE: the array has no reset; stale contents are never observed because
    // rdata is forced to zero whenever the occupancy counter says empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? pkt_t'('0) : mem_q[rd_ptr_q];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));
    a_count_in_range:    assert property (@(posedge clk) disable iff (!reset) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/mesh_inject_queue.sv
// Source-side injection queue. Buffers producer packets and presents the head
// to the mesh, requesting injection (si) only when the mesh is ready and the
// head's VC bit matches the current polarity. Mismatched heads block the
// queue in place; nothing is reordered or dropped. Counts injected packets.
module mesh_inject_queue
    import mesh_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PKT_W-1:0]           src_packet,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic [PKT_W-1:0]           in_packet,
    output logic                       si,
    input  logic                       ro,
    input  logic                       polarity,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           sent_count
);

    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    packet_t    head;
    logic [CNT_W-1:0] sent_count_q, sent_count_d;

    mesh_pkt_fifo #(
        .DEPTH (DEPTH),
        .pkt_t (packet_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (src_packet),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // Handshake and injection gating. src_ready depends on registered
    // occupancy only, so a same-cycle pop never reopens a full queue.
    always_comb begin
        src_ready    = reset & ~fifo_full;
        push         = src_valid & src_ready;
        si           = reset & ~fifo_empty & ro & (pkt_vc(head) == polarity);
        pop          = si;
        sent_count_d = sent_count_q + CNT_W'(pop);
    end

    // Injected-packet counter; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sent_count_q <= '0;
        else        sent_count_q <= sent_count_d;
    end

    assign in_packet  = head;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_mesh_inject_queue.sv
// Self-checking bench for mesh_inject_queue: a per-cycle vector table for
// fill/drain and polarity gating, hand sequences for streaming, counter wrap
// and mid-operation reset, and a scoreboard that checks injection order.
module tb_mesh_inject_queue;

    logic        clk;
    logic        reset;
    logic [63:0] src_packet;
    logic        src_valid;
    logic        src_ready;
    logic [63:0] in_packet;
    logic        si;
    logic        ro;
    logic        polarity;
    logic [2:0]  occupancy;
    logic [31:0] sent_count;

    // Second instance with a 2-bit counter to exercise wraparound cheaply.
    logic        w_src_ready;
    logic [63:0] w_in_packet;
    logic        w_si;
    logic [2:0]  w_occupancy;
    logic [1:0]  w_sent_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    mesh_inject_queue #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .src_packet(src_packet), .src_valid(src_valid),
        .src_ready(src_ready), .in_packet(in_packet), .si(si), .ro(ro),
        .polarity(polarity), .occupancy(occupancy), .sent_count(sent_count)
    );

    mesh_inject_queue #(.DEPTH(4), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .src_packet(src_packet), .src_valid(src_valid),
        .src_ready(w_src_ready), .in_packet(w_in_packet), .si(w_si), .ro(ro),
        .polarity(polarity), .occupancy(w_occupancy), .sent_count(w_sent_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: record accepted pushes, compare each injection against the
    // oldest outstanding packet.
    always @(posedge clk) begin
        if (reset) begin
            if (si) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_inject: got packet %h expected no injection", in_packet);
                end else begin
                    check("sb_order", in_packet, sb_q.pop_front());
                end
            end
            if (src_valid && src_ready) sb_q.push_back(src_packet);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [63:0] pkt;
        logic        ro;
        logic        pol;
        logic        rdy;
        logic        si;
        logic [2:0]  occ;
        logic [63:0] head;
    } vec_t;

    localparam int NV = 16;
    localparam logic [63:0] VC1 = 64'h8000_0000_0000_0000;
    vec_t vecs [NV];

    initial begin
        // Fill to full with ro=0, then drain; row 5 offers a packet while full
        // and popping, which must still be refused.
        vecs[0]  = '{1'b1, 64'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vecs[1]  = '{1'b1, 64'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 64'hB0};
        vecs[2]  = '{1'b1, 64'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 64'hB0};
        vecs[3]  = '{1'b1, 64'hB3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 64'hB0};
        vecs[4]  = '{1'b1, 64'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 64'hB0};
        vecs[5]  = '{1'b1, 64'hB5, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 64'hB0};
        vecs[6]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64'hB1};
        vecs[7]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 64'hB2};
        vecs[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 64'hB3};
        vecs[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        // Polarity gating: VC=1 head blocked for 3 cycles at polarity 0.
        vecs[10] = '{1'b1, VC1 | 64'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0};
        vecs[11] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, VC1 | 64'hC0};
        vecs[12] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, VC1 | 64'hC0};
        vecs[13] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, VC1 | 64'hC0};
        vecs[14] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b1, 3'd1, VC1 | 64'hC0};
        vecs[15] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0};

        // Reset held with a valid producer and a ready mesh.
        reset      = 1'b0;
        src_valid  = 1'b1;
        src_packet = 64'hDEAD_BEEF_0000_0001;
        ro         = 1'b1;
        polarity   = 1'b0;
        #1;
        check("rst_si",        64'(si),         64'd0);
        check("rst_src_ready", 64'(src_ready),  64'd0);
        check("rst_occupancy", 64'(occupancy),  64'd0);
        check("rst_sent",      64'(sent_count), 64'd0);
        check("rst_in_packet", in_packet,       64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_occupancy", 64'(occupancy), 64'd0);
        check("rst_hold_si",        64'(si),        64'd0);
        reset = 1'b1;

        // First packet: no fall-through, injects the cycle after the push.
        src_packet = 64'h0000_0000_0000_00A1;
        #1;
        check("t1_ready", 64'(src_ready), 64'd1);
        check("t1_si_empty", 64'(si), 64'd0);
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        check("t1_si", 64'(si), 64'd1);
        check("t1_in_packet", in_packet, 64'hA1);
        check("t1_occ", 64'(occupancy), 64'd1);
        @(negedge clk);
        #1;
        check("t1_sent", 64'(sent_count), 64'd1);
        check("t1_occ_after", 64'(occupancy), 64'd0);

        for (int i = 0; i < NV; i++) begin
            src_valid  = vecs[i].v;
            src_packet = vecs[i].pkt;
            ro         = vecs[i].ro;
            polarity   = vecs[i].pol;
            #1;
            check($sformatf("vec%0d_ready", i), 64'(src_ready), 64'(vecs[i].rdy));
            check($sformatf("vec%0d_si", i),    64'(si),        64'(vecs[i].si));
            check($sformatf("vec%0d_occ", i),   64'(occupancy), 64'(vecs[i].occ));
            check($sformatf("vec%0d_head", i),  in_packet,      vecs[i].head);
            @(negedge clk);
        end
        #1;
        check("vec_sent", 64'(sent_count), 64'd6);
        check("vec_sb_drained", 64'(sb_q.size()), 64'd0);

        // Streaming: hold occupancy at 2 with a push and a pop every cycle.
        polarity   = 1'b0;
        ro         = 1'b0;
        src_valid  = 1'b1;
        src_packet = 64'hD0;
        @(negedge clk);
        src_packet = 64'hD1;
        @(negedge clk);
        #1;
        check("stream_prefill_occ", 64'(occupancy), 64'd2);
        for (int i = 0; i < 10; i++) begin
            src_valid  = 1'b1;
            src_packet = 64'hE000 + 64'(i);
            ro         = 1'b1;
            #1;
            check($sformatf("stream%0d_occ", i), 64'(occupancy), 64'd2);
            check($sformatf("stream%0d_si", i),  64'(si),        64'd1);
            @(negedge clk);
        end
        src_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stream_occ_drained", 64'(occupancy), 64'd0);
        check("stream_sent", 64'(sent_count), 64'd18);

        // Counter wrap on the 2-bit instance: 18 -> 19 (=3) -> 20 (=0).
        src_valid  = 1'b1;
        src_packet = 64'hF10;
        ro         = 1'b0;
        @(negedge clk);
        src_valid = 1'b0;
        ro        = 1'b1;
        @(negedge clk);
        #1;
        check("wrap_pre", 64'(w_sent_count), 64'd3);
        src_valid  = 1'b1;
        src_packet = 64'hF11;
        ro         = 1'b0;
        @(negedge clk);
        src_valid = 1'b0;
        ro        = 1'b1;
        @(negedge clk);
        #1;
        check("wrap_zero", 64'(w_sent_count), 64'd0);
        check("wrap_main", 64'(sent_count), 64'd20);

        // Mid-operation reset with three packets queued and the mesh ready.
        ro        = 1'b0;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_packet = 64'hF0 + 64'(i);
            @(negedge clk);
        end
        src_valid = 1'b0;
        #1;
        check("mid_occ3", 64'(occupancy), 64'd3);
        ro = 1'b1;
        #1;
        check("mid_si_before", 64'(si), 64'd1);
        #1;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("mid_si_async", 64'(si), 64'd0);
        check("mid_ready_async", 64'(src_ready), 64'd0);
        check("mid_occ_async", 64'(occupancy), 64'd0);
        check("mid_head_async", in_packet, 64'd0);
        @(negedge clk);
        #1;
        check("mid_sent_reset", 64'(sent_count), 64'd0);
        check("mid_wrap_reset", 64'(w_sent_count), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("mid_idle%0d_si", i), 64'(si), 64'd0);
            check($sformatf("mid_idle%0d_occ", i), 64'(occupancy), 64'd0);
        end
        src_valid  = 1'b1;
        src_packet = 64'h0000_0000_0000_00C7;
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        check("mid_new_si", 64'(si), 64'd1);
        check("mid_new_head", in_packet, 64'hC7);
        @(negedge clk);
        #1;
        check("mid_new_sent", 64'(sent_count), 64'd1);
        check("mid_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mesh_inject_queue.md
Name: mesh_inject_queue

Overview:
Source-side network interface that sits directly upstream of the mesh injection port. It accepts 64-bit packets from a local producer over a valid/ready handshake and buffers them in a small FIFO. It drives in_packet/si into the mesh, injecting only when the mesh reports ro=1 and the head packet's VC bit matches the current polarity. It also exposes occupancy and an injected-packet counter for scoreboarding.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PKT_W, 64, packet width; fixed by mesh_pkg, not overridden per instance.
CNT_W, 32, width of sent_count.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
src_packet  input  PKT_W  packet from local producer
src_valid  input  1  producer offers src_packet
src_ready  output  1  queue can accept; push = src_valid & src_ready
in_packet  output  PKT_W  packet presented to mesh (FIFO head)
si  output  1  send request to mesh; a packet is consumed in every cycle si=1
ro  input  1  mesh ready for injection
polarity  input  1  current mesh polarity (even/odd VC phase)
occupancy  output  $clog2(DEPTH+1)  entries currently stored
sent_count  output  CNT_W  packets injected since reset

Behaviour:
- Reset (reset=0, async): FIFO pointers cleared, occupancy=0, sent_count=0, src_ready=0, si=0, in_packet=0. Outputs take these values immediately, without waiting for clk. The first rising edge after reset deasserts can accept a push.
- src_ready = reset & (occupancy != DEPTH). Registered state only; no combinational path from ro or si.
- Push: on a clk edge with src_valid & src_ready, src_packet is written at the tail and occupancy increments.
- Head: in_packet = FIFO head when occupancy>0, otherwise 0.
- Injection: si = (occupancy>0) & ro & (head[VC_BIT] == polarity). Combinational, so the mesh samples si in the same cycle. Pop occurs on that cycle's edge.
- Minimum latency: a push into an empty queue at edge N makes the packet visible at the head after edge N. The earliest si is in cycle N+1, so there is no fall-through bypass.
- Simultaneous push and pop: allowed whenever src_ready=1. Occupancy is unchanged and ordering is preserved (strict FIFO).
- Full: src_ready=0. A pop in the same cycle does not reopen src_ready until the next cycle.
- Empty: si=0 regardless of ro and polarity.
- Polarity mismatch: the head blocks (head-of-line blocking, by design). No reordering and no packet loss.
- ro=0: si=0 and the head is held stable.
- Pointers wrap modulo DEPTH. Occupancy is tracked explicitly, not by pointer difference alone.
- sent_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-operation: all stored packets are discarded. si falls immediately and nothing is injected on the edge coinciding with reset assertion.
- src_packet/src_valid are X-tolerant while src_ready=0. Assertions: no push when full, no pop when empty, occupancy<=DEPTH.

Decomposition:
- mesh_pkg:
  - PKT_W=64.
  - VC_BIT=63.
  - typedef logic [PKT_W-1:0] packet_t.
  - Field localparams for the rest of the header, shared with the mesh and the bench.
- Sub-module mesh_pkt_fifo (DEPTH, packet_t):
  - Ports: clk, reset, push, wdata, pop, rdata, full, empty, count.
- mesh_inject_queue adds the polarity gating, the handshake glue and sent_count.

Test Plan:
- Reset check: hold reset=0 with src_valid=1 -> si=0, src_ready=0, occupancy=0, sent_count=0. Release, then push 0x0000_0000_0000_00A1 (VC=0) with ro=1, polarity=0 -> si=1 in the next cycle, in_packet=0x...A1, sent_count=1 after that edge.
- Fill to full: DEPTH=4, ro=0, push 5 packets back-to-back -> the first 4 are accepted, src_ready=0 on the 5th, occupancy=4. Raise ro with matching polarity -> 4 injections in order on consecutive cycles.
- Polarity gating: head VC=1, ro=1, polarity=0 for 3 cycles -> si=0 and the head is held. Set polarity=1 -> si=1 that cycle and the packet is popped.
- Simultaneous push and pop at occupancy=2 for 10 cycles -> occupancy stays 2, output order equals input order, sent_count +10.
- Counter wrap: force sent_count to 0xFFFF_FFFF, inject one packet -> sent_count=0.
- Mid-operation reset: occupancy=3, ro=1, assert reset=0 between edges -> si drops to 0 without a clock edge. After release, occupancy=0 and no stale packet is ever injected.
